// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: function codes, flag bit positions and FSM states.
package alu_pkg;

  typedef enum logic [4:0] {
    FnA    = 5'd0,
    FnB    = 5'd1,
    FnINC  = 5'd2,
    FnDEC  = 5'd3,
    FnADD  = 5'd4,
    FnADC  = 5'd5,
    FnSUB  = 5'd6,
    FnSUC  = 5'd7,
    FnNEG  = 5'd8,
    FnAND  = 5'd9,
    FnOR   = 5'd10,
    FnXOR  = 5'd11,
    FnNOT  = 5'd12,
    FnNAND = 5'd13,
    FnNOR  = 5'd14,
    FnLUI  = 5'd15,
    FnLLI  = 5'd16,
    FnLSL  = 5'd17,
    FnLSR  = 5'd18,
    FnASR  = 5'd19,
    FnMUL  = 5'd20
  } alu_func_t;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } alu_state_t;

  function automatic logic is_shift(alu_func_t f);
    return (f == FnLSL) || (f == FnLSR) || (f == FnASR);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU core: result and next flag values for logic, move and add/subtract ops.
module alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  alu_func_t        i_func,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_flags,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_flags
);

  localparam int unsigned HALF = WIDTH / 2;

  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic             w_ovf;
  logic             w_arith;
  logic             w_known;

  // Every arithmetic op is one adder pass: subtraction feeds ~B with a carry-in.
  always_comb begin
    w_op_a = i_a;
    w_op_b = '0;
    w_cin  = 1'b0;
    case (i_func)
      FnINC: w_cin = 1'b1;
      FnDEC: begin
        w_op_b = ~WIDTH'(1);
        w_cin  = 1'b1;
      end
      FnADD: w_op_b = i_b;
      FnADC: begin
        w_op_b = i_b;
        w_cin  = i_flags[FLAG_C];
      end
      FnSUB: begin
        w_op_b = ~i_b;
        w_cin  = 1'b1;
      end
      FnSUC: begin
        w_op_b = ~i_b;
        w_cin  = i_flags[FLAG_C];
      end
      FnNEG: begin
        w_op_a = '0;
        w_op_b = ~i_b;
        w_cin  = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_sum = {1'b0, w_op_a} + {1'b0, w_op_b} + {{WIDTH{1'b0}}, w_cin};
  assign w_ovf = (w_op_a[WIDTH-1] == w_op_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_op_a[WIDTH-1]);

  always_comb begin
    o_result = '0;
    w_arith  = 1'b0;
    w_known  = 1'b1;
    case (i_func)
      FnA:    o_result = i_a;
      FnB:    o_result = i_b;
      FnINC, FnDEC, FnADD, FnADC, FnSUB, FnSUC, FnNEG: begin
        o_result = w_sum[WIDTH-1:0];
        w_arith  = 1'b1;
      end
      FnAND:  o_result = i_a & i_b;
      FnOR:   o_result = i_a | i_b;
      FnXOR:  o_result = i_a ^ i_b;
      FnNOT:  o_result = ~i_a;
      FnNAND: o_result = ~(i_a & i_b);
      FnNOR:  o_result = ~(i_a | i_b);
      FnLUI:  o_result = {i_b[HALF-1:0], i_a[HALF-1:0]};
      FnLLI:  o_result = {i_a[WIDTH-1:HALF], i_b[HALF-1:0]};
      // Zero-length shift degenerates to a move of A.
      FnLSL, FnLSR, FnASR: o_result = i_a;
      default: w_known = 1'b0;
    endcase

    o_flags = i_flags;
    if (w_known) begin
      o_flags[FLAG_Z] = (o_result == '0);
      o_flags[FLAG_N] = o_result[WIDTH-1];
    end
    if (w_arith) begin
      o_flags[FLAG_C] = w_sum[WIDTH];
      o_flags[FLAG_V] = w_ovf;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: Start/Done handshake, flag register, bit-serial shifts and shift-add multiply.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned  WIDTH = 16,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [4:0]       i_func,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [SHW-1:0]   i_sh_amt,
  input  logic             i_flag_we,
  input  logic             i_flag_load,
  input  logic [3:0]       i_flag_in,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_flags,
  output logic             o_busy,
  output logic             o_done
);

  alu_state_t         r_state;
  alu_func_t          r_func;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_work;
  logic [2*WIDTH-1:0] r_prod;
  logic [SHW-1:0]     r_count;
  logic               r_flag_we;
  logic [WIDTH-1:0]   r_result;
  logic [3:0]         r_flags;
  logic               r_busy;
  logic               r_done;

  alu_func_t          w_func;
  logic               w_accept;
  logic               w_multi;
  logic               w_complete;
  logic [WIDTH-1:0]   w_core_result;
  logic [3:0]         w_core_flags;
  logic [WIDTH-1:0]   w_shift_next;
  logic               w_shift_out;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_prod_next;
  logic [WIDTH-1:0]   w_fin_result;
  logic [3:0]         w_fin_flags;

  alu_comb #(
    .WIDTH(WIDTH)
  ) u_alu_comb (
    .i_func  (r_func),
    .i_a     (r_a),
    .i_b     (r_b),
    .i_flags (r_flags),
    .o_result(w_core_result),
    .o_flags (w_core_flags)
  );

  assign w_func     = alu_func_t'(i_func);
  assign w_accept   = i_start && !r_busy;
  assign w_multi    = (w_func == FnMUL) || (is_shift(w_func) && (i_sh_amt != '0));
  assign w_complete = (r_state == StDone) || ((r_state == StRun) && (r_count == '0));

  always_comb begin
    w_shift_next = {r_work[WIDTH-2:0], 1'b0};
    w_shift_out  = r_work[WIDTH-1];
    if (r_func == FnLSR) begin
      w_shift_next = {1'b0, r_work[WIDTH-1:1]};
      w_shift_out  = r_work[0];
    end else if (r_func == FnASR) begin
      w_shift_next = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
      w_shift_out  = r_work[0];
    end
  end

  // Upper half accumulates A when the current multiplier bit (LSB) is set, then the pair shifts.
  assign w_mul_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + ({(WIDTH+1){r_prod[0]}} & {1'b0, r_a});
  assign w_prod_next = {w_mul_sum, r_prod[WIDTH-1:1]};

  always_comb begin
    w_fin_result = w_core_result;
    w_fin_flags  = w_core_flags;
    if (r_state == StRun) begin
      w_fin_flags = r_flags;
      if (r_func == FnMUL) begin
        w_fin_result        = w_prod_next[WIDTH-1:0];
        w_fin_flags[FLAG_C] = |w_prod_next[2*WIDTH-1:WIDTH];
      end else begin
        w_fin_result        = w_shift_next;
        w_fin_flags[FLAG_C] = w_shift_out;
      end
      w_fin_flags[FLAG_Z] = (w_fin_result == '0);
      w_fin_flags[FLAG_N] = w_fin_result[WIDTH-1];
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_func    <= FnA;
      r_a       <= '0;
      r_b       <= '0;
      r_work    <= '0;
      r_prod    <= '0;
      r_count   <= '0;
      r_flag_we <= 1'b0;
      r_result  <= '0;
      r_flags   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_complete) begin
        r_result <= w_fin_result;
        r_done   <= 1'b1;
        r_busy   <= 1'b0;
        r_state  <= StIdle;
      end
      if (r_state == StRun) begin
        r_work  <= w_shift_next;
        r_prod  <= w_prod_next;
        r_count <= r_count - SHW'(1);
      end
      // A new request in the completion cycle overrides the return to idle.
      if (w_accept) begin
        r_func    <= w_func;
        r_a       <= i_a;
        r_b       <= i_b;
        r_work    <= i_a;
        r_prod    <= {{WIDTH{1'b0}}, i_b};
        r_flag_we <= i_flag_we;
        if (w_multi) begin
          r_state <= StRun;
          r_busy  <= 1'b1;
          r_count <= (w_func == FnMUL) ? SHW'(WIDTH - 1) : (i_sh_amt - SHW'(1));
        end else begin
          r_state <= StDone;
        end
      end
      if (i_flag_load) begin
        r_flags <= i_flag_in;
      end else if (w_complete && r_flag_we) begin
        r_flags <= w_fin_flags;
      end
    end
  end

  assign o_result = r_result;
  assign o_flags  = r_flags;
  assign o_busy   = r_busy;
  assign o_done   = r_done;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=16): directed cases and randomized ops against a behavioural model.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int unsigned W = 16;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic [4:0]  i_func;
  logic [15:0] i_a;
  logic [15:0] i_b;
  logic [3:0]  i_sh_amt;
  logic        i_flag_we;
  logic        i_flag_load;
  logic [3:0]  i_flag_in;
  logic [15:0] o_result;
  logic [3:0]  o_flags;
  logic        o_busy;
  logic        o_done;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [3:0]  m_flags;
  logic [15:0] m_result;

  alu_seq #(
    .WIDTH(W)
  ) dut (
    .i_clock    (clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_func     (i_func),
    .i_a        (i_a),
    .i_b        (i_b),
    .i_sh_amt   (i_sh_amt),
    .i_flag_we  (i_flag_we),
    .i_flag_load(i_flag_load),
    .i_flag_in  (i_flag_in),
    .o_result   (o_result),
    .o_flags    (o_flags),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected outcome from the arithmetic meaning of each op (true unsigned/signed values).
  function automatic void model(input logic [4:0] f, input logic [15:0] a, input logic [15:0] b,
                                input logic [3:0] sh, input logic [3:0] fl,
                                output logic [15:0] res, output logic [3:0] nf,
                                output int lat, output bit multi);
    int ua, ub, sa, sb, ut, st, ci;
    bit arith, sub_type, zn;
    logic [31:0] p;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    ci = int'(fl[1]);
    nf = fl; lat = 1; multi = 1'b0; arith = 1'b0; sub_type = 1'b0; zn = 1'b1;
    res = '0; ut = 0; st = 0;
    case (f)
      FnA:    res = a;
      FnB:    res = b;
      FnINC:  begin ut = ua + 1;            st = sa + 1;            arith = 1; end
      FnDEC:  begin ut = ua - 1;            st = sa - 1;            arith = 1; sub_type = 1; end
      FnADD:  begin ut = ua + ub;           st = sa + sb;           arith = 1; end
      FnADC:  begin ut = ua + ub + ci;      st = sa + sb + ci;      arith = 1; end
      FnSUB:  begin ut = ua - ub;           st = sa - sb;           arith = 1; sub_type = 1; end
      FnSUC:  begin ut = ua - ub - 1 + ci;  st = sa - sb - 1 + ci;  arith = 1; sub_type = 1; end
      FnNEG:  begin ut = 0 - ub;            st = 0 - sb;            arith = 1; sub_type = 1; end
      FnAND:  res = a & b;
      FnOR:   res = a | b;
      FnXOR:  res = a ^ b;
      FnNOT:  res = ~a;
      FnNAND: res = ~(a & b);
      FnNOR:  res = ~(a | b);
      FnLUI:  res = {b[7:0], a[7:0]};
      FnLLI:  res = {a[15:8], b[7:0]};
      FnLSL, FnLSR, FnASR: begin
        res = a;
        if (sh != 0) begin
          lat = int'(sh); multi = 1'b1;
          if (f == FnLSL) begin
            res = a << sh; nf[1] = a[16 - int'(sh)];
          end else if (f == FnLSR) begin
            res = a >> sh; nf[1] = a[int'(sh) - 1];
          end else begin
            res = $signed(a) >>> sh; nf[1] = a[int'(sh) - 1];
          end
        end
      end
      FnMUL: begin
        p = {16'h0, a} * {16'h0, b};
        res = p[15:0]; nf[1] = (p[31:16] != 16'h0);
        lat = 16; multi = 1'b1;
      end
      default: zn = 1'b0;
    endcase
    if (arith) begin
      res   = ut[15:0];
      nf[1] = sub_type ? (ut >= 0) : (ut > 65535);
      nf[2] = (st > 32767) || (st < -32768);
    end
    if (zn) begin
      nf[0] = (res == 16'h0);
      nf[3] = res[15];
    end
  endfunction

  // Issue one op in the current (or next) cycle; poke>0 retries Start at that cycle of the run.
  task automatic run_op(input string tag, input logic [4:0] f, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] sh, input logic we,
                        input int poke, input bit fload);
    logic [15:0] e_res;
    logic [3:0]  e_nf, e_flags;
    int          e_lat, n;
    bit          e_multi, got;
    model(f, a, b, sh, m_flags, e_res, e_nf, e_lat, e_multi);
    e_flags = fload ? 4'hA : (we ? e_nf : m_flags);
    @(negedge clk);
    i_start = 1'b1; i_func = f; i_a = a; i_b = b; i_sh_amt = sh; i_flag_we = we;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_a = 16'($urandom); i_b = 16'($urandom); i_func = 5'($urandom);
    i_sh_amt = 4'($urandom); i_flag_we = 1'($urandom);
    check_eq({tag, ".busy"}, 32'(o_busy), 32'(e_multi));
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      if (poke != 0 && n == poke) begin
        i_start = 1'b1; i_a = 16'($urandom); i_b = 16'($urandom);
      end
      if (fload && (n + 1 == e_lat)) begin
        i_flag_load = 1'b1; i_flag_in = 4'hA;
      end
      @(posedge clk); n++; #1;
      i_start = 1'b0; i_flag_load = 1'b0; i_flag_in = 4'h0;
      got = o_done;
    end
    check_eq({tag, ".lat"}, 32'(n), 32'(e_lat));
    check_eq({tag, ".res"}, 32'(o_result), 32'(e_res));
    check_eq({tag, ".flags"}, 32'(o_flags), 32'(e_flags));
    check_eq({tag, ".busy_done"}, 32'(o_busy), 32'd0);
    m_flags = e_flags;
    m_result = e_res;
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk); #1;
    check_eq({tag, ".done_low"}, 32'(o_done), 32'd0);
    check_eq({tag, ".hold"}, 32'(o_result), 32'(m_result));
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int pulses;
    logic [4:0] f;
    i_reset = 1'b1; i_start = 1'b0; i_func = '0; i_a = '0; i_b = '0; i_sh_amt = '0;
    i_flag_we = 1'b0; i_flag_load = 1'b0; i_flag_in = '0;
    m_flags = '0; m_result = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst.result", 32'(o_result), 32'h0);
    check_eq("rst.flags", 32'(o_flags), 32'h0);
    check_eq("rst.busy", 32'(o_busy), 32'h0);
    check_eq("rst.done", 32'(o_done), 32'h0);
    i_reset = 1'b0;

    run_op("add_ovf", FnADD, 16'h7FFF, 16'h0001, 4'd0, 1'b1, 0, 1'b0);
    check_eq("add_ovf.const", 32'({o_flags, o_result}), 32'h0C_8000);
    idle_check("add_ovf");
    run_op("sub_eq", FnSUB, 16'h0005, 16'h0005, 4'd0, 1'b1, 0, 1'b0);
    check_eq("sub_eq.const", 32'(o_flags), 32'h3);
    run_op("adc", FnADC, 16'h0001, 16'h0001, 4'd0, 1'b0, 0, 1'b0);
    check_eq("adc.const", 32'(o_result), 32'h3);
    run_op("and_keep_c", FnAND, 16'h00FF, 16'h0F0F, 4'd0, 1'b1, 0, 1'b0);
    check_eq("and_keep_c.c", 32'(o_flags[1]), 32'h1);
    run_op("lsr4", FnLSR, 16'h8001, 16'h0000, 4'd4, 1'b1, 0, 1'b0);
    check_eq("lsr4.const", 32'(o_result), 32'h0800);
    run_op("asr15", FnASR, 16'h8000, 16'h0000, 4'd15, 1'b1, 0, 1'b0);
    check_eq("asr15.const", 32'(o_result), 32'hFFFF);
    run_op("load_c", FnA, 16'h0001, 16'h0000, 4'd0, 1'b1, 0, 1'b1);
    run_op("lsl0", FnLSL, 16'h1234, 16'h0000, 4'd0, 1'b1, 0, 1'b0);
    check_eq("lsl0.c_kept", 32'(o_flags[1]), 32'h1);
    run_op("mul_3x5", FnMUL, 16'h0003, 16'h0005, 4'd0, 1'b1, 6, 1'b0);
    check_eq("mul_3x5.const", 32'(o_result), 32'h000F);
    idle_check("mul_3x5");
    run_op("mul_hi", FnMUL, 16'h0100, 16'h0100, 4'd0, 1'b1, 0, 1'b0);
    check_eq("mul_hi.const", 32'(o_flags & 4'h3), 32'h3);
    run_op("mul_fload", FnMUL, 16'h0007, 16'h0009, 4'd0, 1'b1, 0, 1'b1);
    check_eq("mul_fload.const", 32'(o_flags), 32'hA);
    run_op("unknown", 5'd25, 16'h1234, 16'h5678, 4'd0, 1'b1, 0, 1'b0);
    idle_check("unknown");

    @(negedge clk);
    i_start = 1'b1; i_func = FnMUL; i_a = 16'h1234; i_b = 16'h5678; i_flag_we = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_eq("abort.busy_mid", 32'(o_busy), 32'h1);
    i_reset = 1'b1;
    @(posedge clk); #1;
    i_reset = 1'b0;
    check_eq("abort.busy", 32'(o_busy), 32'h0);
    check_eq("abort.done", 32'(o_done), 32'h0);
    check_eq("abort.result", 32'(o_result), 32'h0);
    check_eq("abort.flags", 32'(o_flags), 32'h0);
    pulses = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (o_done) pulses++;
    end
    check_eq("abort.no_done", 32'(pulses), 32'h0);
    m_flags = '0; m_result = '0;

    for (int i = 0; i < 150; i++) begin
      f = 5'($urandom_range(0, 31));
      run_op($sformatf("rnd%0d", i), f, pick(), pick(), 4'($urandom), 1'($urandom),
             (f == FnMUL) ? int'($urandom_range(1, 15)) : 0, $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) idle_check($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
